timer_irq_ctrl: RTL and testbench

Programmable interrupt timer for the picorv32 SoC.
- Shares the same tick source style as the free-running timebase: a CLK_DIV prescaler advances a 32-bit counter.
- Adds a compare register, one-shot/periodic modes, pending/overrun status and a level IRQ to the CPU.
- Sits on the CPU memory bus as a 4-word register block. Read data follows the OR-bus convention.

---
 rtl/timer_ctrl_pkg.sv | 41 ++++
 rtl/timer_irq_ctrl_if.sv | 18 +
 rtl/timer_tick_gen.sv | 32 +++
 rtl/timer_irq_ctrl.sv | 128 ++++++++++++
 tb/tb_timer_irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the programmable interrupt timer.
//   - register word indices, CTRL/STATUS bit positions, bus widths
//   - apply_wstrb(): byte-lane merge used by every writable register
package timer_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CTRL_W = 3;

    typedef enum logic [ADDR_W-1:0] {
        REG_CTRL    = 2'd0,
        REG_COMPARE = 2'd1,
        REG_COUNT   = 2'd2,
        REG_STATUS  = 2'd3
    } reg_idx_e;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;

    localparam int unsigned ST_PEND = 0;
    localparam int unsigned ST_OVR  = 1;

    // Replace only the byte lanes selected by strb.
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] wdata,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// CPU memory-bus port of the interrupt timer.
//   cs/addr/wstrb/di : request from the CPU side (master)
//   dout             : registered read data (the bus name "do" is a reserved word)
//   irq              : level interrupt to the CPU
interface timer_irq_ctrl_if;
    import timer_ctrl_pkg::*;

    logic              cs;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] dout;
    logic              irq;

    modport master (output cs, addr, wstrb, di, input  dout, irq);
    modport slave  (input  cs, addr, wstrb, di, output dout, irq);

endinterface

// File: rtl/timer_tick_gen.sv
// CLK_DIV prescaler: tick_c pulses for one cycle every CLK_DIV enabled cycles.
//   clk, resetn : clock, async active-low reset
//   en          : count enable; prescaler is held at 0 while low
//   tick_c      : combinational tick, high on the last prescaler phase
module timer_tick_gen #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_q;

    // Prescaler phase register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else if (!en || pre_q == PRE_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    assign tick_c = en && (pre_q == PRE_LAST);

endmodule

// File: rtl/timer_irq_ctrl.sv
// Programmable interrupt timer: prescaled 32-bit counter, compare match,
// one-shot/periodic modes, PEND/OVR status and a level IRQ.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : 4-word register block (CTRL, COMPARE, COUNT, STATUS),
//                 1-cycle read latency, dout is 0 after any unselected cycle
// Build option: define TIMER_CTRL_OVR_EN to implement the STATUS.OVR flag;
// otherwise STATUS bit1 reads 0 and ignores writes.
module timer_irq_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic              clk,
    input  logic              resetn,
    timer_irq_ctrl_if.slave   bus
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovr_rd;

    logic              tick_c;
    logic              match_c;
    logic [DATA_W-1:0] cnt_inc_c;
    logic [DATA_W-1:0] rdata_c;
    logic              wr_c, rd_c;
    logic              w1c_pend_c;

    timer_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .en     (ctrl_q[CTRL_EN]),
        .tick_c (tick_c)
    );

    assign wr_c       = bus.cs && (bus.wstrb != '0);
    assign rd_c       = bus.cs && (bus.wstrb == '0);
    assign cnt_inc_c  = cnt_q + DATA_W'(1);
    // Compare value 0 disables matching; a match always sees the pre-write COMPARE.
    assign match_c    = tick_c && (cmp_q != '0) && (cnt_inc_c == cmp_q);
    assign w1c_pend_c = wr_c && (bus.addr == REG_STATUS) && bus.wstrb[0] && bus.di[ST_PEND];

`ifdef TIMER_CTRL_OVR_EN
    logic ovr_q, ovr_d;
    logic w1c_ovr_c;

    assign w1c_ovr_c = wr_c && (bus.addr == REG_STATUS) && bus.wstrb[0] && bus.di[ST_OVR];
    // A match while PEND is still set is an overrun; set beats a simultaneous clear.
    assign ovr_d     = (match_c && pend_q) || (ovr_q && !w1c_ovr_c);
    assign ovr_rd    = ovr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end
`else
    assign ovr_rd = 1'b0;
`endif

    // Read mux of the current register contents.
    always_comb begin
        rdata_c = '0;
        case (bus.addr)
            REG_CTRL:    rdata_c = DATA_W'(ctrl_q);
            REG_COMPARE: rdata_c = cmp_q;
            REG_COUNT:   rdata_c = cnt_q;
            REG_STATUS:  rdata_c = DATA_W'({ovr_rd, pend_q});
            default:     rdata_c = '0;
        endcase
    end

    // Next-state for all registers; bus writes take priority over timer updates.
    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        cnt_d  = cnt_q;
        pend_d = match_c || (pend_q && !w1c_pend_c);
        dout_d = rd_c ? rdata_c : '0;

        if (match_c && !ctrl_q[CTRL_PERIODIC]) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_c && bus.addr == REG_CTRL && bus.wstrb[0]) begin
            ctrl_d = bus.di[CTRL_W-1:0];
        end

        if (wr_c && bus.addr == REG_COMPARE) begin
            cmp_d = apply_wstrb(cmp_q, bus.di, bus.wstrb);
        end

        if (wr_c && bus.addr == REG_COUNT) begin
            cnt_d = apply_wstrb(cnt_q, bus.di, bus.wstrb);
        end else if (match_c) begin
            cnt_d = ctrl_q[CTRL_PERIODIC] ? '0 : cmp_q;
        end else if (tick_c) begin
            cnt_d = cnt_inc_c;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q <= '0;
            cmp_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            dout_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cmp_q  <= cmp_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.irq  = pend_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed scenarios plus random bus
// traffic, checked every cycle against an event-level reference model.
module tb_timer_irq_ctrl;

    localparam int unsigned CLK_DIV = 12;
`ifdef TIMER_CTRL_OVR_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic clk;
    logic resetn;

    timer_irq_ctrl_if bus();

    timer_irq_ctrl #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    bit          m_en, m_per, m_ie, m_pend, m_ovr, m_irq;
    logic [31:0] m_cmp, m_cnt, m_do;
    int unsigned m_run;   // edges elapsed since the timer was last enabled

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_ovr = 0; m_irq = 0;
        m_cmp = '0; m_cnt = '0; m_do = '0; m_run = 0;
    endtask

    // One clock edge of the timer, from the register-level rules.
    task automatic model_edge(input logic c, input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        bit wr, rd, tick, match;
        logic [31:0] rv, nxt;
        bit n_en, n_per, n_ie, n_pend, n_ovr;
        logic [31:0] n_cmp, n_cnt;
        wr = c && (s != 4'h0);
        rd = c && (s == 4'h0);
        case (a)
            2'd0:    rv = {29'h0, m_ie, m_per, m_en};
            2'd1:    rv = m_cmp;
            2'd2:    rv = m_cnt;
            default: rv = {30'h0, OVR_ON & m_ovr, m_pend};
        endcase
        tick  = m_en && (((m_run + 1) % CLK_DIV) == 0);
        nxt   = m_cnt + 32'd1;
        match = tick && (m_cmp != 0) && (nxt == m_cmp);

        n_en = m_en; n_per = m_per; n_ie = m_ie;
        if (match && !m_per) n_en = 0;
        if (wr && a == 2'd0 && s[0]) begin
            n_en = d[0]; n_per = d[1]; n_ie = d[2];
        end
        n_cmp = (wr && a == 2'd1) ? lane_merge(m_cmp, d, s) : m_cmp;
        if (wr && a == 2'd2)  n_cnt = lane_merge(m_cnt, d, s);
        else if (match)       n_cnt = m_per ? 32'h0 : m_cmp;
        else if (tick)        n_cnt = nxt;
        else                  n_cnt = m_cnt;
        n_pend = m_pend; n_ovr = m_ovr;
        if (wr && a == 2'd3 && s[0]) begin
            if (d[0]) n_pend = 0;
            if (d[1]) n_ovr = 0;
        end
        if (match) begin
            if (m_pend) n_ovr = 1;
            n_pend = 1;
        end
        if (!OVR_ON) n_ovr = 0;

        m_run  = m_en ? m_run + 1 : 0;
        m_en = n_en; m_per = n_per; m_ie = n_ie;
        m_cmp = n_cmp; m_cnt = n_cnt; m_pend = n_pend; m_ovr = n_ovr;
        m_do  = rd ? rv : 32'h0;
        m_irq = m_pend && m_ie;
    endtask

    task automatic step(input logic c, input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.cs = c; bus.addr = a; bus.wstrb = s; bus.di = d;
        @(posedge clk);
        model_edge(c, a, s, d);
        cyc++;
        #1;
        check("do", bus.dout, m_do);
        check("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        step(1'b1, a, s, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        step(1'b1, a, 4'h0, 32'h0);
        v = bus.dout;
    endtask

    task automatic wait_irq(input int max, output int n);
        n = 0;
        while (!bus.irq && n < max) begin
            idle();
            n++;
        end
    endtask

    initial begin
        logic [31:0] v;
        int n, c0, m1;
        logic [1:0] ra;
        logic [3:0] rs;
        logic [31:0] rd_v;

        bus.cs = 0; bus.addr = '0; bus.wstrb = '0; bus.di = '0;
        resetn = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_do", bus.dout, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        @(negedge clk) resetn = 1;

        // Reset readback and unselected cycles
        repeat (3) idle();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            check("rst_reg", v, 32'h0);
        end

        // Periodic mode
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'h7, 4'hF);
        wait_irq(100, n);
        check("per_latency", 32'(n), 32'd36);
        m1 = cyc;
        rd(2'd2, v);  check("per_count0", v, 32'h0);
        rd(2'd3, v);  check("per_status", v, 32'h1);
        wr(2'd3, 32'h1, 4'hF);
        idle();
        wait_irq(100, n);
        check("per_period", 32'(cyc - m1), 32'd36);
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd3, 32'h3, 4'hF);
        wr(2'd2, 32'h0, 4'hF);

        // One-shot mode
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h5, 4'hF);
        wait_irq(100, n);
        check("os_latency", 32'(n), 32'd60);
        rd(2'd0, v);  check("os_ctrl", v, 32'h4);
        rd(2'd2, v);  check("os_count", v, 32'd5);
        wr(2'd3, 32'h1, 4'hF);
        repeat (150) idle();
        rd(2'd3, v);  check("os_nopend", v, 32'h0);

        // Overrun and W1C coincident with a match
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd3, 32'h3, 4'hF);
        wr(2'd2, 32'h0, 4'hF);
        wr(2'd1, 32'd1, 4'hF);
        wr(2'd0, 32'h3, 4'hF);
        c0 = cyc;
        while (cyc < c0 + 30) idle();
        rd(2'd3, v);  check("ovr_set", v, OVR_ON ? 32'h3 : 32'h1);
        while (cyc < c0 + 35) idle();
        wr(2'd3, 32'h1, 4'hF);
        rd(2'd3, v);  check("w1c_vs_set", v, OVR_ON ? 32'h3 : 32'h1);
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd3, 32'h3, 4'hF);

        // Byte strobes (timer stopped)
        wr(2'd2, 32'h11223344, 4'hF);
        wr(2'd2, 32'hAA000000, 4'b1000);
        rd(2'd2, v);  check("byte_lane", v, 32'hAA223344);

        // COUNT write coincident with a tick
        wr(2'd1, 32'h0, 4'hF);
        wr(2'd2, 32'h0, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        c0 = cyc;
        while (cyc < c0 + 11) idle();
        wr(2'd2, 32'h55, 4'hF);
        rd(2'd2, v);  check("wr_beats_tick", v, 32'h55);

        // Silent wrap with COMPARE=0
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd3, 32'h3, 4'hF);
        wr(2'd2, 32'hFFFFFFFF, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        c0 = cyc;
        while (cyc < c0 + 12) idle();
        rd(2'd2, v);  check("wrap_count", v, 32'h0);
        rd(2'd3, v);  check("wrap_status", v, 32'h0);

        // Random bus traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                idle();
            end else if (r < 85) begin
                rd(2'($urandom_range(0, 3)), v);
            end else begin
                ra = 2'($urandom_range(0, 3));
                rs = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
                case (ra)
                    2'd0:    rd_v = 32'($urandom_range(0, 7));
                    2'd1:    rd_v = 32'($urandom_range(0, 8));
                    2'd2:    rd_v = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 6));
                    default: rd_v = 32'($urandom_range(0, 3));
                endcase
                wr(ra, rd_v, rs);
            end
        end

        // Asynchronous reset in the middle of counting with irq active
        wr(2'd2, 32'h0, 4'hF);
        wr(2'd3, 32'h3, 4'hF);
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h7, 4'hF);
        wait_irq(100, n);
        check("pre_rst_irq", 32'(bus.irq), 32'h1);
        #2 resetn = 0;
        #1;
        check("async_rst_irq", 32'(bus.irq), 32'h0);
        check("async_rst_do", bus.dout, 32'h0);
        model_reset();
        @(negedge clk) resetn = 1;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            check("post_rst_reg", v, 32'h0);
        end
        repeat (30) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
